// File: rtl/mem_copy_dma_if.sv
// Bus bundle for the memory-copy DMA: copy request inputs plus the shared
// mem_cmd/mem_addr/read_data/write_data initiator protocol.
interface mem_copy_dma_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] read_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_cmd;
  logic [DATA_W-1:0] write_data;
  logic              busy;
  logic              done;

  // DMA side: takes requests and read returns, drives the bus
  modport master (
    input  start, src, dst, len, read_data,
    output mem_addr, mem_cmd, write_data, busy, done
  );

  // Environment side: issues requests and services the bus
  modport slave (
    output start, src, dst, len, read_data,
    input  mem_addr, mem_cmd, write_data, busy, done
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine. Each word takes three bus cycles:
// MREAD (address phase), MREAD held (data returns), MWRITE.
module mem_copy_dma #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  mem_copy_dma_if.master bus
);
  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_MREAD  = 2'b01;
  localparam logic [1:0] CMD_MWRITE = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WR, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [DATA_W-1:0] hold_reg, hold_next;

  // State, pointers, remaining count and read holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
    end
  end

  // Next-state logic and bus outputs, decoded from state and registers only
  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    count_next     = count_reg;
    hold_next      = hold_reg;
    bus.mem_cmd    = CMD_NONE;
    bus.mem_addr   = '0;
    bus.write_data = hold_reg;
    bus.busy       = (state_reg != IDLE);
    bus.done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          src_next   = bus.src;
          dst_next   = bus.dst;
          count_next = bus.len;
          state_next = (bus.len == '0) ? DONE : RD_ADDR;
        end
      end
      RD_ADDR: begin
        bus.mem_cmd  = CMD_MREAD;
        bus.mem_addr = src_reg;
        state_next   = RD_WAIT;
      end
      RD_WAIT: begin
        // Read data is valid in the second MREAD cycle; capture it here
        bus.mem_cmd  = CMD_MREAD;
        bus.mem_addr = src_reg;
        hold_next    = bus.read_data;
        state_next   = WR;
      end
      WR: begin
        bus.mem_cmd  = CMD_MWRITE;
        bus.mem_addr = dst_reg;
        src_next     = src_reg + 1'b1;
        dst_next     = dst_reg + 1'b1;
        count_next   = count_reg - 1'b1;
        state_next   = (count_reg == ADDR_W'(1)) ? DONE : RD_ADDR;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: a bus RAM model with one I/O read
// port (SW at 0x140) and one I/O write port (LEDR at 0x100), and a scoreboard
// of expected bus transactions built from a shadow memory.
module tb_mem_copy_dma;
  localparam int AW = 9;
  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic clk;
  logic reset;
  mem_copy_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus slave model
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic [7:0]    sw;
  logic [7:0]    ledr;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  // Registered read, writes on MWRITE, backdoor loader for preloading
  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (bus.mem_cmd == 2'b11) begin
      ram[bus.mem_addr] <= bus.write_data;
      if (bus.mem_addr == 9'h100) ledr <= bus.write_data[7:0];
    end
    if (bus.mem_cmd == 2'b01)
      rd_q <= (bus.mem_addr == 9'h140) ? {8'h00, sw} : ram[bus.mem_addr];
  end
  assign bus.read_data = rd_q;

  // Scoreboard state
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  txn_t exp_q[$];
  txn_t obs_q[$];
  txn_t e, o;
  int checks, errors, cyc, done_cnt, done_cyc;

  // Advance to the next falling edge and record what the DUT presented
  task automatic step();
    txn_t t;
    @(negedge clk);
    cyc++;
    if (bus.mem_cmd != 2'b00) begin
      t.cmd  = bus.mem_cmd;
      t.addr = bus.mem_addr;
      t.data = (bus.mem_cmd == 2'b11) ? bus.write_data : '0;
      obs_q.push_back(t);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Predict the bus transactions of a copy and update the shadow memory
  task automatic push_copy(input logic [AW-1:0] s_in, d_in, input int n);
    logic [AW-1:0] s, d;
    logic [DW-1:0] v;
    s = s_in; d = d_in;
    for (int i = 0; i < n; i++) begin
      v = (s == 9'h140) ? {8'h00, sw} : model_mem[s];
      exp_q.push_back('{2'b01, s, 16'h0000});
      exp_q.push_back('{2'b01, s, 16'h0000});
      exp_q.push_back('{2'b11, d, v});
      model_mem[d] = v;
      s = s + 1'b1;
      d = d + 1'b1;
    end
  endtask

  task automatic launch(input logic [AW-1:0] s, d, n);
    bus.src = s; bus.dst = d; bus.len = n; bus.start = 1'b1;
    cyc = 0; done_cnt = 0; done_cyc = 0;
    obs_q.delete();
    $display("copy src=%h dst=%h len=%0d", s, d, n);
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.len = 9'd1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.mem_cmd !== 2'b00) begin errors++; $display("FAIL reset_cmd got %b exp 00", bus.mem_cmd); end
    if (bus.mem_addr !== 9'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", bus.mem_addr); end
    if (bus.write_data !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h exp 0000", bus.write_data); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    bus.start = 1'b0; reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    poke(9'h010, 16'h0011); poke(9'h011, 16'h0022); poke(9'h012, 16'h0033);
    exp_q.delete();
    push_copy(9'h010, 9'h040, 3);
    launch(9'h010, 9'h040, 9'd3);
    for (int i = 0; i < 100 && done_cnt == 0; i++) step();
    repeat (3) step();
    checks += 3;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    if (done_cyc != 10) begin errors++; $display("FAIL basic_done_cycle got %0d exp 10", done_cyc); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", bus.busy); end
    for (int a = 'h40; a <= 'h42; a++) begin
      checks++;
      if (ram[a] !== model_mem[a]) begin errors++; $display("FAIL basic_ram[%h] got %h exp %h", a, ram[a], model_mem[a]); end
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL basic_bus_count got %0d exp %0d left", obs_q.size(), exp_q.size()); break;
      end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL basic_bus got %h exp %h", o, e); end
    end
  endtask

  task automatic test_len_zero();
    poke(9'h006, 16'h1234);
    exp_q.delete();
    launch(9'h005, 9'h006, 9'd0);
    repeat (8) step();
    checks += 4;
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_cnt); end
    if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL zero_bus_cmds got %0d exp 0", obs_q.size()); end
    if (ram[6] !== 16'h1234) begin errors++; $display("FAIL zero_ram got %h exp 1234", ram[6]); end
  endtask

  task automatic test_wrap();
    poke(9'h1FF, 16'hC1C1); poke(9'h000, 16'hC2C2);
    exp_q.delete();
    push_copy(9'h1FF, 9'h0FE, 2);
    launch(9'h1FF, 9'h0FE, 9'd2);
    for (int i = 0; i < 100 && done_cnt == 0; i++) step();
    repeat (2) step();
    checks += 3;
    if (done_cyc != 7) begin errors++; $display("FAIL wrap_done_cycle got %0d exp 7", done_cyc); end
    if (ram[9'h0FE] !== 16'hC1C1) begin errors++; $display("FAIL wrap_ram0 got %h exp c1c1", ram[9'h0FE]); end
    if (ram[9'h0FF] !== 16'hC2C2) begin errors++; $display("FAIL wrap_ram1 got %h exp c2c2", ram[9'h0FF]); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL wrap_bus_count got %0d exp %0d left", obs_q.size(), exp_q.size()); break;
      end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL wrap_bus got %h exp %h", o, e); end
    end
  endtask

  task automatic test_io();
    sw = 8'hA5;
    exp_q.delete();
    push_copy(9'h140, 9'h100, 1);
    launch(9'h140, 9'h100, 9'd1);
    for (int i = 0; i < 100 && done_cnt == 0; i++) step();
    repeat (2) step();
    checks += 2;
    if (ledr !== 8'hA5) begin errors++; $display("FAIL io_ledr got %h exp a5", ledr); end
    if (done_cyc != 4) begin errors++; $display("FAIL io_done_cycle got %0d exp 4", done_cyc); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL io_bus_count got %0d exp %0d left", obs_q.size(), exp_q.size()); break;
      end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL io_bus got %h exp %h", o, e); end
    end
  endtask

  task automatic test_overlap();
    poke(9'h020, 16'hBEEF); poke(9'h021, 16'h1111); poke(9'h022, 16'h2222); poke(9'h023, 16'h3333);
    exp_q.delete();
    push_copy(9'h020, 9'h021, 3);
    launch(9'h020, 9'h021, 9'd3);
    for (int i = 0; i < 100 && done_cnt == 0; i++) step();
    repeat (2) step();
    for (int a = 'h21; a <= 'h23; a++) begin
      checks++;
      if (ram[a] !== 16'hBEEF) begin errors++; $display("FAIL overlap_ram[%h] got %h exp beef", a, ram[a]); end
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL overlap_bus_count got %0d exp %0d left", obs_q.size(), exp_q.size()); break;
      end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL overlap_bus got %h exp %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    poke(9'h060, 16'h6161); poke(9'h061, 16'h6262);
    poke(9'h068, 16'h0F0F); poke(9'h069, 16'h0E0E);
    exp_q.delete();
    push_copy(9'h060, 9'h068, 1);
    exp_q.push_back('{2'b01, 9'h061, 16'h0000});
    exp_q.push_back('{2'b01, 9'h061, 16'h0000});
    launch(9'h060, 9'h068, 9'd4);
    repeat (4) step();             // now sampling RD_WAIT of word 2
    reset = 1'b1;
    step();
    checks += 2;
    if (bus.mem_cmd !== 2'b00) begin errors++; $display("FAIL abort_cmd got %b exp 00", bus.mem_cmd); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    reset = 1'b0;
    repeat (30) step();
    checks += 3;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
    if (ram[9'h068] !== 16'h6161) begin errors++; $display("FAIL abort_word1 got %h exp 6161", ram[9'h068]); end
    if (ram[9'h069] !== 16'h0E0E) begin errors++; $display("FAIL abort_word2 got %h exp 0e0e", ram[9'h069]); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL abort_bus_count got %0d exp %0d left", obs_q.size(), exp_q.size()); break;
      end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL abort_bus got %h exp %h", o, e); end
    end
  endtask

  task automatic test_start_ignored();
    poke(9'h070, 16'h7070); poke(9'h071, 16'h7171); poke(9'h072, 16'h7272);
    poke(9'h090, 16'h9090); poke(9'h098, 16'hDEAD);
    exp_q.delete();
    push_copy(9'h070, 9'h078, 3);
    launch(9'h070, 9'h078, 9'd3);
    repeat (3) step();
    bus.src = 9'h090; bus.dst = 9'h098; bus.len = 9'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 100 && done_cnt == 0; i++) step();
    repeat (12) step();
    checks += 3;
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", done_cnt); end
    if (done_cyc != 10) begin errors++; $display("FAIL ignore_done_cycle got %0d exp 10", done_cyc); end
    if (ram[9'h098] !== 16'hDEAD) begin errors++; $display("FAIL ignore_new_dst got %h exp dead", ram[9'h098]); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL ignore_bus_count got %0d exp %0d left", obs_q.size(), exp_q.size()); break;
      end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL ignore_bus got %h exp %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    poke(9'h030, 16'h5A5A);
    exp_q.delete();
    push_copy(9'h030, 9'h050, 1);
    push_copy(9'h030, 9'h050, 1);
    bus.src = 9'h030; bus.dst = 9'h050; bus.len = 9'd1; bus.start = 1'b1;
    cyc = 0; done_cnt = 0; done_cyc = 0; obs_q.delete();
    $display("copy src=030 dst=050 len=1 with start held");
    repeat (6) step();             // start held through DONE and the next IDLE
    bus.start = 1'b0;
    for (int i = 0; i < 100 && done_cnt < 2; i++) step();
    repeat (4) step();
    checks += 3;
    if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt); end
    if (done_cyc != 9) begin errors++; $display("FAIL b2b_done_cycle got %0d exp 9", done_cyc); end
    if (ram[9'h050] !== 16'h5A5A) begin errors++; $display("FAIL b2b_ram got %h exp 5a5a", ram[9'h050]); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL b2b_bus_count got %0d exp %0d left", obs_q.size(), exp_q.size()); break;
      end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL b2b_bus got %h exp %h", o, e); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
    reset = 1'b1; sw = 8'h00; ledr = 8'h00;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_io();
    test_overlap();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
